// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Instruction queue between fetch (IF) and decode (ID). Accepts {pc, instr}
//   pairs from fetch with a valid/ready handshake and presents them to decode
//   in program order, with the head visible without a read request. A flush
//   discards all queued entries, for example on a branch or exception redirect.
//
// Ports
//   clk, rst_n            core clock; asynchronous active-low reset
//   flush_i               synchronous discard of all entries
//   if_valid_i/_ready_o   fetch-side handshake
//   if_pc_i, if_instr_i   incoming pair
//   id_valid_o/_ready_i   decode-side handshake
//   id_pc_o, id_instr_o   head pair (0 / NOP when empty)
//   count_o               number of occupied entries
module fetch_buffer #(
   parameter int          DEPTH = 4,
   parameter logic [31:0] NOP   = 32'h0000_0013
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     if_valid_i,
   input  logic [63:0]              if_pc_i,
   input  logic [31:0]              if_instr_i,
   output logic                     if_ready_o,
   output logic                     id_valid_o,
   output logic [63:0]              id_pc_o,
   output logic [31:0]              id_instr_o,
   input  logic                     id_ready_i,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [63:0]   r_pc_mem    [DEPTH];
   logic [31:0]   r_instr_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_push;
   logic w_pop;

   // Ready depends only on occupancy, so a full queue refuses a push even
   // when decode is popping in the same cycle. This keeps if_ready_o free of
   // any combinational path from id_ready_i.
   assign if_ready_o = (r_count != CW'(DEPTH));
   assign id_valid_o = (r_count != '0);
   assign count_o    = r_count;

   assign w_push = if_valid_i & if_ready_o & ~flush_i;
   assign w_pop  = id_valid_o & id_ready_i & ~flush_i;

   // The head is read straight from storage. A new pair therefore shows up
   // one cycle after it is pushed, because there is no write-to-read bypass.
   assign id_pc_o    = id_valid_o ? r_pc_mem[r_rd_ptr]    : 64'd0;
   assign id_instr_o = id_valid_o ? r_instr_mem[r_rd_ptr] : NOP;

   // Storage has no reset: the count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]    <= if_pc_i;
         r_instr_mem[r_wr_ptr] <= if_instr_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
      w_push |-> (r_count != CW'(DEPTH)));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
      w_pop |-> (r_count != '0));
   a_count_range:  assert property (@(posedge clk) disable iff (!rst_n)
      r_count <= CW'(DEPTH));

endmodule
